// File: rtl/mem_lsu.sv
`timescale 1ns/1ps
// mem_lsu: load/store unit between the MEM stage and the AXI data master.
// Aligns byte addresses to 8-byte bus words, builds byte strobes and lane-shifted
// store data, and returns shifted, sign/zero-extended load data or a misalign error.
module mem_lsu #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_req_we,
    input  logic [2:0]            lsu_req_funct3,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,

    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
    output logic                  lsu_resp_err,

    output logic [63:0]           data_addr,
    output logic                  data_rd_addr_valid,
    input  logic [DATA_WIDTH-1:0] data_rd,
    input  logic                  data_rd_valid,
    output logic                  data_wr_valid,
    output logic [7:0]            data_wmask,
    output logic [DATA_WIDTH-1:0] data_wr,
    input  logic                  data_wr_ready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    // Misalignment: natural alignment required for H, W and D accesses.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            2'd1:    mis = off[0];
            2'd2:    mis = (off[1:0] != 2'b00);
            2'd3:    mis = (off != 3'b000);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte strobes for the access size, placed at the byte offset in the word.
    function automatic logic [STRB_W-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [STRB_W-1:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return STRB_W'(base << off);
    endfunction

    // Shift the bus beat down to the addressed byte and extend to 64 bits.
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] beat,
                                                      input logic [2:0]            f3,
                                                      input logic [OFF_W-1:0]      off);
        logic [DATA_WIDTH-1:0] sh;
        logic                  sx;
        logic [DATA_WIDTH-1:0] res;
        sh = beat >> {off, 3'b000};
        case (f3[1:0])
            2'd0: begin
                sx  = sh[7] & ~f3[2];
                res = {{56{sx}}, sh[7:0]};
            end
            2'd1: begin
                sx  = sh[15] & ~f3[2];
                res = {{48{sx}}, sh[15:0]};
            end
            2'd2: begin
                sx  = sh[31] & ~f3[2];
                res = {{32{sx}}, sh[31:0]};
            end
            default: begin
                sx  = 1'b0;
                res = sh;
            end
        endcase
        return res;
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [63:0]           bus_addr_q, bus_addr_d;
    logic                  rd_addr_valid_q, rd_addr_valid_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [STRB_W-1:0]     wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] ld_data_c;

    // Next-state, request latch and registered-output decode of the next state.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        ld_data_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (lsu_req_valid) begin
                    addr_d   = lsu_req_addr;
                    funct3_d = lsu_req_funct3;
                    wdata_d  = lsu_req_wdata;
                    err_d    = is_misaligned(lsu_req_funct3[1:0], lsu_req_addr[OFF_W-1:0]);
                    if (err_d) begin
                        state_d = ST_RESP;
                    end else if (lsu_req_we) begin
                        state_d = ST_WR_WAIT;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (data_rd_valid) begin
                    ld_data_c = extract(data_rd, funct3_q, addr_q[OFF_W-1:0]);
                    state_d   = ST_RESP;
                end
            end
            ST_WR_WAIT: begin
                if (data_wr_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are flopped copies of what the next state implies.
        req_ready_d     = (state_d == ST_IDLE);
        rd_addr_valid_d = (state_d == ST_RD_WAIT);
        wr_valid_d      = (state_d == ST_WR_WAIT);
        bus_addr_d      = '0;
        wmask_d         = '0;
        wr_data_d       = '0;
        if (state_d == ST_RD_WAIT || state_d == ST_WR_WAIT) begin
            bus_addr_d = 64'({addr_d[ADDR_WIDTH-1:OFF_W], 3'b000});
        end
        if (state_d == ST_WR_WAIT) begin
            wmask_d   = lane_mask(funct3_d[1:0], addr_d[OFF_W-1:0]);
            wr_data_d = wdata_d << {addr_d[OFF_W-1:0], 3'b000};
        end
        resp_valid_d = (state_d == ST_RESP);
        resp_err_d   = (state_d == ST_RESP) && err_d;
        resp_rdata_d = ((state_d == ST_RESP) && !err_d) ? ld_data_c : '0;
    end

    // State, request latch and output registers; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            funct3_q        <= '0;
            wdata_q         <= '0;
            err_q           <= 1'b0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_err_q      <= 1'b0;
            bus_addr_q      <= '0;
            rd_addr_valid_q <= 1'b0;
            wr_valid_q      <= 1'b0;
            wmask_q         <= '0;
            wr_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            funct3_q        <= funct3_d;
            wdata_q         <= wdata_d;
            err_q           <= err_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            bus_addr_q      <= bus_addr_d;
            rd_addr_valid_q <= rd_addr_valid_d;
            wr_valid_q      <= wr_valid_d;
            wmask_q         <= wmask_d;
            wr_data_q       <= wr_data_d;
        end
    end

    assign lsu_req_ready      = req_ready_q;
    assign lsu_resp_valid     = resp_valid_q;
    assign lsu_resp_rdata     = resp_rdata_q;
    assign lsu_resp_err       = resp_err_q;
    assign data_addr          = bus_addr_q;
    assign data_rd_addr_valid = rd_addr_valid_q;
    assign data_wr_valid      = wr_valid_q;
    assign data_wmask         = wmask_q;
    assign data_wr            = wr_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
// tb_mem_lsu: directed load/store/misalign/reset vectors with hand-computed results.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_we;
    logic [2:0]  lsu_req_funct3;
    logic [63:0] lsu_req_addr;
    logic [63:0] lsu_req_wdata;
    logic        lsu_resp_valid;
    logic [63:0] lsu_resp_rdata;
    logic        lsu_resp_err;
    logic [63:0] data_addr;
    logic        data_rd_addr_valid;
    logic [63:0] data_rd;
    logic        data_rd_valid;
    logic        data_wr_valid;
    logic [7:0]  data_wmask;
    logic [63:0] data_wr;
    logic        data_wr_ready;

    int errors = 0;
    int checks = 0;

    mem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .lsu_req_valid      (lsu_req_valid),
        .lsu_req_ready      (lsu_req_ready),
        .lsu_req_we         (lsu_req_we),
        .lsu_req_funct3     (lsu_req_funct3),
        .lsu_req_addr       (lsu_req_addr),
        .lsu_req_wdata      (lsu_req_wdata),
        .lsu_resp_valid     (lsu_resp_valid),
        .lsu_resp_rdata     (lsu_resp_rdata),
        .lsu_resp_err       (lsu_resp_err),
        .data_addr          (data_addr),
        .data_rd_addr_valid (data_rd_addr_valid),
        .data_rd            (data_rd),
        .data_rd_valid      (data_rd_valid),
        .data_wr_valid      (data_wr_valid),
        .data_wmask         (data_wmask),
        .data_wr            (data_wr),
        .data_wr_ready      (data_wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports each mismatch.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata);
        lsu_req_valid  = 1'b1;
        lsu_req_we     = we;
        lsu_req_funct3 = f3;
        lsu_req_addr   = addr;
        lsu_req_wdata  = wdata;
        step();
        lsu_req_valid  = 1'b0;
    endtask

    task automatic load_op(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] beat, input int lat,
                           input logic [63:0] exp_baddr, input logic [63:0] exp_rdata);
        issue(1'b0, f3, addr, 64'h0);
        chk({tag, ".rd_addr"}, data_addr, exp_baddr);
        chk({tag, ".ready_low"}, 64'(lsu_req_ready), 64'h0);
        for (int i = 0; i < lat; i++) begin
            chk({tag, ".rd_av_held"}, 64'(data_rd_addr_valid), 64'h1);
            step();
        end
        chk({tag, ".rd_av"}, 64'(data_rd_addr_valid), 64'h1);
        chk({tag, ".no_wr"}, 64'(data_wr_valid), 64'h0);
        data_rd       = beat;
        data_rd_valid = 1'b1;
        step();
        data_rd_valid = 1'b0;
        data_rd       = 64'h0;
        chk({tag, ".resp_v"}, 64'(lsu_resp_valid), 64'h1);
        chk({tag, ".rdata"}, lsu_resp_rdata, exp_rdata);
        chk({tag, ".err"}, 64'(lsu_resp_err), 64'h0);
        chk({tag, ".rd_av_drop"}, 64'(data_rd_addr_valid), 64'h0);
        chk({tag, ".addr_zero"}, data_addr, 64'h0);
        step();
        chk({tag, ".resp_once"}, 64'(lsu_resp_valid), 64'h0);
        chk({tag, ".ready_back"}, 64'(lsu_req_ready), 64'h1);
    endtask

    task automatic store_op(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] wdata, input int lat,
                            input logic [63:0] exp_baddr, input logic [7:0] exp_mask,
                            input logic [63:0] exp_wr);
        issue(1'b1, f3, addr, wdata);
        chk({tag, ".wr_addr"}, data_addr, exp_baddr);
        chk({tag, ".wmask"}, 64'(data_wmask), 64'(exp_mask));
        chk({tag, ".wdata"}, data_wr, exp_wr);
        for (int i = 0; i < lat; i++) begin
            chk({tag, ".wr_v_held"}, 64'(data_wr_valid), 64'h1);
            chk({tag, ".no_resp"}, 64'(lsu_resp_valid), 64'h0);
            step();
        end
        chk({tag, ".wr_v"}, 64'(data_wr_valid), 64'h1);
        chk({tag, ".wmask_held"}, 64'(data_wmask), 64'(exp_mask));
        chk({tag, ".no_rd"}, 64'(data_rd_addr_valid), 64'h0);
        data_wr_ready = 1'b1;
        step();
        data_wr_ready = 1'b0;
        chk({tag, ".resp_v"}, 64'(lsu_resp_valid), 64'h1);
        chk({tag, ".rdata0"}, lsu_resp_rdata, 64'h0);
        chk({tag, ".err"}, 64'(lsu_resp_err), 64'h0);
        chk({tag, ".wr_v_drop"}, 64'(data_wr_valid), 64'h0);
        chk({tag, ".wmask0"}, 64'(data_wmask), 64'h0);
        step();
        chk({tag, ".resp_once"}, 64'(lsu_resp_valid), 64'h0);
    endtask

    task automatic misalign_op(input string tag, input logic we, input logic [2:0] f3,
                               input logic [63:0] addr);
        issue(we, f3, addr, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, ".resp_v"}, 64'(lsu_resp_valid), 64'h1);
        chk({tag, ".err"}, 64'(lsu_resp_err), 64'h1);
        chk({tag, ".rdata0"}, lsu_resp_rdata, 64'h0);
        chk({tag, ".no_wr"}, 64'(data_wr_valid), 64'h0);
        chk({tag, ".no_rd"}, 64'(data_rd_addr_valid), 64'h0);
        step();
        chk({tag, ".resp_once"}, 64'(lsu_resp_valid), 64'h0);
        chk({tag, ".no_wr2"}, 64'(data_wr_valid), 64'h0);
        chk({tag, ".no_rd2"}, 64'(data_rd_addr_valid), 64'h0);
        chk({tag, ".ready"}, 64'(lsu_req_ready), 64'h1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".resp_v"}, 64'(lsu_resp_valid), 64'h0);
        chk({tag, ".resp_err"}, 64'(lsu_resp_err), 64'h0);
        chk({tag, ".rdata"}, lsu_resp_rdata, 64'h0);
        chk({tag, ".rd_av"}, 64'(data_rd_addr_valid), 64'h0);
        chk({tag, ".wr_v"}, 64'(data_wr_valid), 64'h0);
        chk({tag, ".wmask"}, 64'(data_wmask), 64'h0);
        chk({tag, ".wdata"}, data_wr, 64'h0);
        chk({tag, ".addr"}, data_addr, 64'h0);
    endtask

    initial begin
        rst            = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_req_we     = 1'b0;
        lsu_req_funct3 = 3'd0;
        lsu_req_addr   = 64'h0;
        lsu_req_wdata  = 64'h0;
        data_rd        = 64'h0;
        data_rd_valid  = 1'b0;
        data_wr_ready  = 1'b0;

        // Reset state
        step();
        step();
        check_all_zero("reset");
        chk("reset.ready", 64'(lsu_req_ready), 64'h1);
        rst = 1'b1;
        step();

        // Loads: LB sign, LHU zero, LW sign, LD, funct3=111 as LD
        load_op("lb",  3'd0, 64'h0000_0000_8000_0005, 64'h0000_8000_0000_0000, 3,
                64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        load_op("lhu", 3'd5, 64'h0000_0000_8000_0006, 64'hBEEF_0000_0000_0000, 0,
                64'h0000_0000_8000_0000, 64'h0000_0000_0000_BEEF);
        load_op("lw",  3'd2, 64'h0000_0000_8000_0010, 64'h1111_1111_8000_0001, 1,
                64'h0000_0000_8000_0010, 64'hFFFF_FFFF_8000_0001);
        load_op("lwu", 3'd6, 64'h0000_0000_8000_0014, 64'hF234_5678_0000_0000, 0,
                64'h0000_0000_8000_0010, 64'h0000_0000_F234_5678);
        load_op("ld",  3'd3, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 2,
                64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF);
        load_op("f3_7", 3'd7, 64'h0000_0000_8000_0018, 64'hF000_0000_0000_0001, 0,
                64'h0000_0000_8000_0018, 64'hF000_0000_0000_0001);

        // Stores: SW with 5-cycle ready delay, SB top lane, SH mid lane, SD aligned
        store_op("sw", 3'd2, 64'h0000_0000_8000_0004, 64'h0000_0000_1234_5678, 5,
                 64'h0000_0000_8000_0000, 8'hF0, 64'h1234_5678_0000_0000);
        store_op("sb", 3'd0, 64'h0000_0000_8000_0007, 64'h0000_0000_0000_00AB, 1,
                 64'h0000_0000_8000_0000, 8'h80, 64'hAB00_0000_0000_0000);
        store_op("sh", 3'd1, 64'h0000_0000_8000_000A, 64'h0000_0000_0000_BEEF, 0,
                 64'h0000_0000_8000_0008, 8'h0C, 64'h0000_0000_BEEF_0000);
        store_op("sd", 3'd3, 64'h0000_0000_8000_0020, 64'hCAFE_F00D_DEAD_BEEF, 2,
                 64'h0000_0000_8000_0020, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF);

        // Misaligned ops: respond with err one cycle after capture, no bus traffic
        misalign_op("sd_mis", 1'b1, 3'd3, 64'h0000_0000_8000_0002);
        misalign_op("lh_mis", 1'b0, 3'd1, 64'h0000_0000_8000_0001);
        misalign_op("lw_mis", 1'b0, 3'd2, 64'h0000_0000_8000_0006);

        // Stray bus completions in IDLE are ignored
        data_rd_valid = 1'b1;
        data_wr_ready = 1'b1;
        step();
        data_rd_valid = 1'b0;
        data_wr_ready = 1'b0;
        chk("stray.resp_v", 64'(lsu_resp_valid), 64'h0);
        chk("stray.ready", 64'(lsu_req_ready), 64'h1);

        // Reset asserted in RD_WAIT: outputs clear at once, no response
        issue(1'b0, 3'd3, 64'h0000_0000_8000_0040, 64'h0);
        chk("rstmid.rd_av", 64'(data_rd_addr_valid), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rstmid");
        data_rd_valid = 1'b1;
        data_rd       = 64'h5555_5555_5555_5555;
        step();
        data_rd_valid = 1'b0;
        data_rd       = 64'h0;
        rst = 1'b1;
        step();
        chk("rstmid.no_resp1", 64'(lsu_resp_valid), 64'h0);
        step();
        chk("rstmid.no_resp2", 64'(lsu_resp_valid), 64'h0);
        load_op("ld_after_rst", 3'd3, 64'h0000_0000_8000_0048, 64'h0A0B_0C0D_0E0F_1011, 1,
                64'h0000_0000_8000_0048, 64'h0A0B_0C0D_0E0F_1011);

        // Back-to-back LD then SD with lsu_req_valid held high
        lsu_req_valid  = 1'b1;
        lsu_req_we     = 1'b0;
        lsu_req_funct3 = 3'd3;
        lsu_req_addr   = 64'h0000_0000_8000_0050;
        lsu_req_wdata  = 64'h0;
        step();
        chk("b2b.ld_av", 64'(data_rd_addr_valid), 64'h1);
        chk("b2b.ld_addr", data_addr, 64'h0000_0000_8000_0050);
        lsu_req_we     = 1'b1;
        lsu_req_addr   = 64'h0000_0000_8000_0058;
        lsu_req_wdata  = 64'h7766_5544_3322_1100;
        step();
        chk("b2b.ld_av_wait", 64'(data_rd_addr_valid), 64'h1);
        chk("b2b.no_wr_yet", 64'(data_wr_valid), 64'h0);
        data_rd_valid = 1'b1;
        data_rd       = 64'h8000_0000_0000_0000;
        step();
        data_rd_valid = 1'b0;
        data_rd       = 64'h0;
        chk("b2b.ld_resp", 64'(lsu_resp_valid), 64'h1);
        chk("b2b.ld_rdata", lsu_resp_rdata, 64'h8000_0000_0000_0000);
        chk("b2b.rd_av_drop", 64'(data_rd_addr_valid), 64'h0);
        chk("b2b.resp_not_ready", 64'(lsu_req_ready), 64'h0);
        chk("b2b.resp_no_wr", 64'(data_wr_valid), 64'h0);
        step();
        chk("b2b.idle_no_resp", 64'(lsu_resp_valid), 64'h0);
        chk("b2b.idle_ready", 64'(lsu_req_ready), 64'h1);
        chk("b2b.idle_no_wr", 64'(data_wr_valid), 64'h0);
        chk("b2b.idle_no_rd", 64'(data_rd_addr_valid), 64'h0);
        step();
        lsu_req_valid = 1'b0;
        chk("b2b.sd_wr_v", 64'(data_wr_valid), 64'h1);
        chk("b2b.sd_addr", data_addr, 64'h0000_0000_8000_0058);
        chk("b2b.sd_mask", 64'(data_wmask), 64'h0000_0000_0000_00FF);
        chk("b2b.sd_data", data_wr, 64'h7766_5544_3322_1100);
        data_wr_ready = 1'b1;
        step();
        data_wr_ready = 1'b0;
        chk("b2b.sd_resp", 64'(lsu_resp_valid), 64'h1);
        chk("b2b.sd_err", 64'(lsu_resp_err), 64'h0);
        step();
        chk("b2b.sd_resp_once", 64'(lsu_resp_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
